// File: rtl/instr_exec_unit.sv
// Instruction sequencer and datapath: fetches 23-bit words from the ROM, executes them
// against an 8 x 16-bit register file, with a restoring 1-bit-per-cycle divider for DIV/MOD.
module instr_exec_unit #(
  parameter int PC_W      = 5,
  parameter int DATA_W    = 16,
  parameter int DIV_STEPS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [22:0]       code,
  input  logic [2:0]        rd_sel,
  output logic [PC_W-1:0]   address,
  output logic              busy,
  output logic              halted,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MOD  = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DIV,
    S_HALT
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [22:0]       ir_q;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] dq_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvsr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        opcode;
  logic [2:0]        rd_idx;
  logic [2:0]        rs_idx;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign opcode = ir_q[22:19];
  assign rd_idx = ir_q[18:16];
  assign rs_idx = ir_q[15:13];
  assign imm    = ir_q[DATA_W-1:0];
  assign op_a   = regs_q[rd_idx];
  assign op_b   = regs_q[rs_idx];

  // Restoring divide step. The remainder stays below the divisor, so the top bit of
  // the difference is exactly the borrow; a zero divisor yields all-ones / original Rd.
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;
  logic              q_bit;
  logic [DATA_W-1:0] rem_d;
  logic [DATA_W-1:0] dq_d;
  logic              div_last;

  assign rem_shift = {rem_q, dq_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign q_bit     = ~rem_diff[DATA_W];
  assign rem_d     = q_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
  assign dq_d      = {dq_q[DATA_W-2:0], q_bit};
  assign div_last  = (state_q == S_DIV) && (cnt_q == CNT_W'(DIV_STEPS - 1));

  logic              alu_wr;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    alu_wr  = 1'b1;
    alu_res = '0;
    case (opcode)
      OP_LOAD: alu_res = imm;
      OP_MOV:  alu_res = op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_wr  = 1'b0;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == S_EXEC && alu_wr) begin
      wr_en   = 1'b1;
      wr_addr = rd_idx;
      wr_data = alu_res;
    end else if (div_last) begin
      wr_en   = 1'b1;
      wr_addr = rd_idx;
      wr_data = (opcode == OP_DIV) ? dq_d : rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
          end
        end
        S_FETCH: begin
          ir_q    <= code;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == OP_HALT) begin
            state_q <= S_HALT;
          end else if (opcode == OP_DIV || opcode == OP_MOD) begin
            dq_q    <= op_a;
            dvsr_q  <= op_b;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end else begin
            pc_q    <= pc_q + PC_W'(1);
            state_q <= S_FETCH;
          end
        end
        S_DIV: begin
          dq_q  <= dq_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (div_last) begin
            pc_q    <= pc_q + PC_W'(1);
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign address = pc_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_DIV);
  assign halted  = (state_q == S_HALT);
  assign rd_data = regs_q[rd_sel];

endmodule
